addsub16_seq: RTL and testbench

- Sequential 16-bit add/subtract unit; the subtract-direction counterpart to the combinational ripple adder16.
- Processes operands one SLICE-bit nibble per cycle through a single 4-bit adder slice, keeping the carry/borrow in a flip-flop.
- Valid/ready handshake on both input and output, so it can sit between a stimulus source and a result consumer in the datapath.

---
 rtl/addsub16_seq.sv | 166 ++++++++++++++++
 tb/tb_addsub16_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub16_seq.sv
// addsub16_seq: sequential add/subtract unit that pushes the operands through
// one SLICE-bit adder slice per cycle, LSB slice first, with the carry/borrow
// held in a flip-flop between slices. Valid/ready handshakes sit on both the
// operand side and the result side.
//
// Optional feature: define ADDSUB_OVF_EN to add the 'ovf' output. It reports
// two's-complement signed overflow, taken from the final slice as the carry
// into the MSB XOR the carry out of the MSB.
//
// Subtraction is done as a + ~b + ~c_in. The operand B is inverted when it is
// captured, so the slice datapath only ever adds. As a result c_out is the raw
// carry, which means that for a subtraction the borrow is ~c_out.

module addsub16_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       opA_q, opA_d;
    logic [WIDTH-1:0]       opB_q, opB_d;
    logic                   carry_q, carry_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WIDTH-SLICE-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]       sum_q, sum_d;
    logic                   cout_q, cout_d;
    logic [SLICE:0]         sliceTotal;
    logic [WIDTH-1:0]       accNext;
`ifdef ADDSUB_OVF_EN
    logic                   ovf_q, ovf_d;
    logic                   msbCarryIn;
`endif

    // The single adder slice always works on the low slice of the shifting
    // operand registers. Shifting them right each cycle is the same as
    // selecting slice [count*SLICE +: SLICE] of the latched operands.
    assign sliceTotal = {1'b0, opA_q[SLICE-1:0]} + {1'b0, opB_q[SLICE-1:0]}
                      + {{SLICE{1'b0}}, carry_q};

    // The new slice result enters at the top of the accumulator. After the
    // last slice, the full word is therefore in LSB-first order.
    assign accNext = {sliceTotal[SLICE-1:0], acc_q};

`ifdef ADDSUB_OVF_EN
    // Recover the carry into the slice MSB from the sum bit of that position.
    assign msbCarryIn = opA_q[SLICE-1] ^ opB_q[SLICE-1] ^ sliceTotal[SLICE-1];
`endif

    // Next-state and datapath update: capture operands, run the slices,
    // publish the result, and then wait for the consumer.
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        carry_d = carry_q;
        count_d = count_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d   = a;
                    opB_d   = b ^ {WIDTH{sub}};
                    carry_d = sub ? ~c_in : c_in;
                    count_d = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opA_d   = opA_q >> SLICE;
                opB_d   = opB_q >> SLICE;
                carry_d = sliceTotal[SLICE];
                acc_d   = accNext[WIDTH-1:SLICE];
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    sum_d   = accNext;
                    cout_d  = sliceTotal[SLICE];
`ifdef ADDSUB_OVF_EN
                    ovf_d   = msbCarryIn ^ sliceTotal[SLICE];
`endif
                    count_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, with a synchronous active-low reset that
    // aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            carry_q <= carry_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = cout_q;
`ifdef ADDSUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_addsub16_seq.sv
// Testbench for addsub16_seq. Directed operand vectors are used, and each one
// has a hand-computed result. A behavioural model computes every result with
// plain integer arithmetic and tracks when the unit is busy, idle or holding a
// result. A per-cycle compare process checks the outputs against that model.
// Define ADDSUB_OVF_EN to also check the overflow output.

module tb_addsub16_seq;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NSL   = WIDTH / SLICE;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        subOp;
    logic        carryIn;
    logic        outValid;
    logic        outReady;
    logic [15:0] sumOut;
    logic        carryOut;
`ifdef ADDSUB_OVF_EN
    logic        ovfOut;
`endif

    int passCount  = 0;
    int checkCount = 0;
    bit checkEn    = 0;

    // Model state: cycles of work left, whether a result is waiting, and the
    // published result values.
    int          mBusy = 0;
    bit          mDone = 0;
    logic [15:0] mSum  = '0;
    logic        mCout = 1'b0;
    logic        mOvf  = 1'b0;
    logic [15:0] pSum;
    logic        pCout;
    logic        pOvf;

    addsub16_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (opA),
        .b         (opB),
        .sub       (subOp),
        .c_in      (carryIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sumOut),
        .c_out     (carryOut)
`ifdef ADDSUB_OVF_EN
        ,
        .ovf       (ovfOut)
`endif
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Behavioural model: the result comes from integer arithmetic on the
    // operands, and the timing comes from the accept / N-cycle / handshake rules.
    always @(posedge clk) begin
        int ua, ub, full, sa, sb, sres;
        if (!rst_n) begin
            mBusy = 0;
            mDone = 0;
            mSum  = '0;
            mCout = 1'b0;
            mOvf  = 1'b0;
        end else if (mDone) begin
            if (outReady) mDone = 0;
        end else if (mBusy > 0) begin
            mBusy--;
            if (mBusy == 0) begin
                mDone = 1;
                mSum  = pSum;
                mCout = pCout;
                mOvf  = pOvf;
            end
        end else if (inValid) begin
            ua = int'(opA);
            ub = int'(opB);
            sa = int'($signed(opA));
            sb = int'($signed(opB));
            if (subOp) begin
                full  = ua - ub - int'(carryIn);
                pCout = (full >= 0);
                sres  = sa - sb - int'(carryIn);
            end else begin
                full  = ua + ub + int'(carryIn);
                pCout = (full > 32'h0000FFFF);
                sres  = sa + sb + int'(carryIn);
            end
            pSum  = full[15:0];
            pOvf  = (sres > 32767) || (sres < -32768);
            mBusy = NSL;
        end
    end

    // On every falling edge, compare all DUT outputs with the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc in_ready", inReady, (!mDone && mBusy == 0));
            checkOutput("cyc out_valid", outValid, mDone);
            checkOutput("cyc sum", sumOut, mSum);
            checkOutput("cyc c_out", carryOut, mCout);
`ifdef ADDSUB_OVF_EN
            checkOutput("cyc ovf", ovfOut, mOvf);
`endif
        end
    end

    // Run one operation. The operand inputs are scrambled during RUN. The
    // result is held for 'hold' cycles under backpressure, and new operands
    // offered during that time must be ignored.
    task automatic applyStimulus(input string name, input logic [15:0] av, input logic [15:0] bv,
                                 input logic sv, input logic cv, input logic [15:0] eSum,
                                 input logic eCout, input logic eOvf, input int hold);
        int lat;
        @(posedge clk);
        #2;
        inValid  = 1'b1;
        opA      = av;
        opB      = bv;
        subOp    = sv;
        carryIn  = cv;
        outReady = (hold == 0);
        @(posedge clk);
        #2;
        inValid = 1'b0;
        opA     = 16'($urandom);
        opB     = 16'($urandom);
        subOp   = 1'($urandom);
        carryIn = 1'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (outValid === 1'b1) break;
        end
        checkOutput({name, " latency"}, lat, NSL);
        checkOutput({name, " sum"}, sumOut, eSum);
        checkOutput({name, " c_out"}, carryOut, eCout);
`ifdef ADDSUB_OVF_EN
        checkOutput({name, " ovf"}, ovfOut, eOvf);
`else
        if (eOvf !== eOvf) $display("[TB] unreachable");
`endif
        for (int i = 0; i < hold; i++) begin
            #1;
            inValid = 1'b1;
            opA     = 16'hAAAA;
            opB     = 16'h5555;
            @(posedge clk);
            #1;
            checkOutput({name, " held sum"}, sumOut, eSum);
            checkOutput({name, " held in_ready"}, inReady, 1'b0);
            checkOutput({name, " held out_valid"}, outValid, 1'b1);
        end
        if (hold > 0) begin
            #1;
            inValid  = 1'b0;
            outReady = 1'b1;
        end
    endtask

    // Main sequence: reset, directed vectors, backpressure, reset abort.
    initial begin
        rst_n    = 1'b0;
        inValid  = 1'b0;
        opA      = '0;
        opB      = '0;
        subOp    = 1'b0;
        carryIn  = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkEn = 1;
        checkOutput("reset in_ready", inReady, 1'b1);
        checkOutput("reset out_valid", outValid, 1'b0);
        checkOutput("reset sum", sumOut, 16'h0000);
        checkOutput("reset c_out", carryOut, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus("add 1234+0FFF", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
        applyStimulus("add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        applyStimulus("add 7FFF+0+1", 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
        applyStimulus("sub 0005-0007", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0);
        applyStimulus("sub 8000-0001", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
        applyStimulus("sub 0010-0001-1", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 0);
        applyStimulus("add A5A5+5A5B bp", 16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3);

        // Reset two cycles into RUN discards the operation.
        @(posedge clk);
        #2;
        inValid = 1'b1;
        opA     = 16'h1111;
        opB     = 16'h2222;
        subOp   = 1'b0;
        carryIn = 1'b0;
        @(posedge clk);
        #2;
        inValid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort out_valid", outValid, 1'b0);
        checkOutput("abort in_ready", inReady, 1'b1);
        checkOutput("abort sum", sumOut, 16'h0000);
        #1;
        rst_n = 1'b1;

        applyStimulus("add 0001+0002+1", 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkEn = 0;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
